// File: rtl/sign_narrow_32to26.sv
// Narrows signed IN_W-bit words to OUT_W-bit fields through a 2-stage valid/ready pipeline,
// flagging words that do not survive re-extension. Define SIGN_NARROW_SATURATE_EN to clamp overflows.
module sign_narrow_32to26 #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 26,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_ovf,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] ovf_count
);

   typedef struct packed {
      logic             fit;
      logic             sign;
      logic [OUT_W-1:0] trunc;
   } s1_t;

   localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic                 s1_valid, s2_valid;
   logic                 s1_adv, s2_adv;
   s1_t                  s1_q, s1_d;
   logic [IN_W-OUT_W:0]  hi;
   logic [OUT_W-1:0]     narrowed;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   // Upper bits including the new sign bit must all match for the value to fit.
   assign hi          = in_data[IN_W-1:OUT_W-1];
   assign s1_d.fit    = (&hi) || !(|hi);
   assign s1_d.sign   = in_data[IN_W-1];
   assign s1_d.trunc  = in_data[OUT_W-1:0];

`ifdef SIGN_NARROW_SATURATE_EN
   assign narrowed = s1_q.fit ? s1_q.trunc : (s1_q.sign ? SAT_NEG : SAT_POS);
`else
   assign narrowed = s1_q.trunc;
`endif

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) s1_q <= s1_d;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
         out_ovf  <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= narrowed;
            out_ovf  <= !s1_q.fit;
         end
      end
   end

   // Clear wins over a coincident overflow delivery; that delivery is not counted.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         ovf_count <= '0;
      else if (cnt_clr)
         ovf_count <= '0;
      else if (s2_valid && out_ready && out_ovf && ovf_count != CNT_MAX)
         ovf_count <= ovf_count + 1'b1;
   end

endmodule

// File: tb/tb_sign_narrow_32to26.sv
// Scoreboard bench for sign_narrow_32to26: arithmetic reference model, queue of expected
// results, independent monitor; small counter width so saturation is reachable.
module tb_sign_narrow_32to26;

   localparam int IN_W  = 32;
   localparam int OUT_W = 26;
   localparam int CNT_W = 4;
   localparam int CMAX  = 15;

   logic             Clk = 1'b0;
   logic             Rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic             out_ovf;
   logic             cnt_clr = 1'b0;
   logic [CNT_W-1:0] ovf_count;

   typedef struct {
      logic [IN_W-1:0]  orig;
      logic [OUT_W-1:0] data;
      logic             ovf;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   mcnt = 0;
   bit   rnd_ready = 0;

   sign_narrow_32to26 #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf),
      .cnt_clr(cnt_clr), .ovf_count(ovf_count)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: range test on the signed value, then wrap or clamp.
   function automatic exp_t model(input logic [IN_W-1:0] w);
      exp_t   e;
      longint v;
      longint lim;
      v     = longint'($signed(w));
      lim   = longint'(1) <<< (OUT_W-1);
      e.orig = w;
      e.ovf  = !(v >= -lim && v < lim);
      e.data = w[OUT_W-1:0];
`ifdef SIGN_NARROW_SATURATE_EN
      if (e.ovf) e.data = (v < 0) ? OUT_W'(lim) : OUT_W'(lim - 1);
`endif
      return e;
   endfunction

   task automatic send(input logic [IN_W-1:0] w);
      int t = 0;
      in_valid = 1'b1;
      in_data  = w;
      @(negedge Clk);
      while (!in_ready && t < 100) begin
         @(negedge Clk);
         t++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         $display("FAIL send_timeout: in_ready stuck 0 for word 0x%0h", w);
      end else begin
         q.push_back(model(w));
      end
      @(posedge Clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (q.size() != 0 && t < 200) begin
         @(posedge Clk); #1;
         t++;
      end
      check("drain_queue_empty", q.size(), 0);
   endtask

   // Monitor: compares every delivered word and the overflow counter against the model.
   logic [OUT_W-1:0] held_data;
   logic             held_ovf;
   bit               holding = 0;
   always @(negedge Clk) begin
      exp_t e;
      if (!Rst_n) begin
         holding = 0;
      end else begin
         check("ovf_count", ovf_count, mcnt);
         if (holding && out_valid) begin
            check("stall_data_stable", out_data, held_data);
            check("stall_ovf_stable", out_ovf, held_ovf);
         end
         holding = 0;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_data);
            end else begin
               e = q.pop_front();
               check("out_data", out_data, e.data);
               check("out_ovf", out_ovf, e.ovf);
               if (!e.ovf) check("reextend", {{(IN_W-OUT_W){out_data[OUT_W-1]}}, out_data}, e.orig);
               if (cnt_clr) mcnt = 0;
               else if (e.ovf && mcnt < CMAX) mcnt++;
            end
         end else begin
            if (cnt_clr) mcnt = 0;
            if (out_valid) begin
               holding   = 1;
               held_data = out_data;
               held_ovf  = out_ovf;
            end
         end
      end
   end

   always @(posedge Clk) begin
      if (rnd_ready) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      int acc;
      int t;
      logic [IN_W-1:0] bp[4];
      repeat (3) @(posedge Clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      check("rst_ovf_count", ovf_count, 0);
      Rst_n = 1'b1;
      @(posedge Clk); #1;
      check("idle_in_ready", in_ready, 1);

      // Directed words.
      out_ready = 1'b1;
      send(32'h0000_0005);
      @(posedge Clk); #1;
      check("latency_out_valid", out_valid, 1);
      check("latency_out_data", out_data, 26'h0000005);
      send(32'hFFFF_FFFB);
      send(32'h0200_0000);
      send(32'hFDFF_FFFF);
      send(32'h01FF_FFFF);
      send(32'hFE00_0000);
      drain();
      check("count_after_directed", ovf_count, 2);

      // Backpressure: only two words fit while the output is stalled.
      out_ready = 1'b0;
      bp = '{32'h1, 32'h2, 32'h3, 32'h4};
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         in_valid = (acc < 4);
         in_data  = bp[acc < 4 ? acc : 3];
         @(negedge Clk);
         if (in_valid && in_ready) begin
            q.push_back(model(bp[acc]));
            acc++;
         end
         @(posedge Clk); #1;
      end
      check("bp_accepted", acc, 2);
      check("bp_in_ready", in_ready, 0);
      check("bp_held_data", out_data, 26'h1);
      out_ready = 1'b1;
      while (acc < 4) begin
         in_valid = 1'b1;
         in_data  = bp[acc];
         @(negedge Clk);
         if (in_ready) begin
            q.push_back(model(bp[acc]));
            acc++;
         end
         @(posedge Clk); #1;
      end
      in_valid = 1'b0;
      drain();

      // Counter saturation.
      for (int i = 0; i < 18; i++) send((i % 2) ? 32'h8000_0000 : 32'h7FFF_FFFF);
      drain();
      check("count_saturated", ovf_count, CMAX);

      // Clear coinciding with an overflow delivery.
      out_ready = 1'b0;
      send(32'h0400_0000);
      t = 0;
      while (!out_valid && t < 20) begin
         @(posedge Clk); #1;
         t++;
      end
      check("clr_word_ready", out_valid, 1);
      cnt_clr   = 1'b1;
      out_ready = 1'b1;
      @(posedge Clk); #1;
      cnt_clr = 1'b0;
      check("clr_priority", ovf_count, 0);
      drain();

      // Randomized traffic with random backpressure.
      rnd_ready = 1;
      for (int i = 0; i < 300; i++) begin
         logic [IN_W-1:0] w;
         case ($urandom_range(0, 3))
            0: w = $urandom();
            1: w = IN_W'($urandom_range(0, 32'h01FF_FFFF));
            2: w = ~IN_W'($urandom_range(0, 32'h01FF_FFFF));
            default: w = IN_W'($urandom_range(32'h01FF_FFF0, 32'h0200_0010));
         endcase
         if ($urandom_range(0, 3) == 0) begin
            @(posedge Clk); #1;
         end
         send(w);
      end
      rnd_ready = 0;
      @(posedge Clk); #2;
      out_ready = 1'b1;
      drain();

      // Async reset with both stages full.
      out_ready = 1'b0;
      send(32'h11);
      send(32'h22);
      check("full_in_ready", in_ready, 0);
      Rst_n = 1'b0;
      #1;
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_ovf_count", ovf_count, 0);
      q.delete();
      mcnt = 0;
      @(posedge Clk); #1;
      Rst_n     = 1'b1;
      out_ready = 1'b1;
      send(32'h7);
      @(posedge Clk); #1;
      check("post_rst_valid", out_valid, 1);
      check("post_rst_data", out_data, 26'h7);
      drain();
      @(posedge Clk); #1;
      check("post_rst_idle", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sign_narrow_32to26.md
Name: sign_narrow_32to26

Overview:
- Inverse of the 26-to-32 sign extender: narrows 32-bit signed values (jump/branch targets, immediates) into 26-bit signed fields.
- Flags values that do not survive the round trip, i.e. where re-extension would not reproduce the input.
- Streaming block: 2-stage pipeline with valid/ready handshake on both sides and a saturating overflow-event counter.
- Sits between the address-generation logic and the instruction-field packer.

Parameters:
IN_W, 32, input word width
OUT_W, 26, output field width (OUT_W < IN_W)
CNT_W, 16, overflow counter width

Ports:
Clk  input  1  clock, rising edge
Rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream word valid
in_ready  output  1  block accepts word this cycle
in_data  input  IN_W  signed value to narrow
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  OUT_W  narrowed value
out_ovf  output  1  value did not fit in OUT_W signed bits
cnt_clr  input  1  synchronous clear of ovf_count
ovf_count  output  CNT_W  number of overflowed words delivered

Behaviour:
- Reset: the async assert of Rst_n=0 clears s1_valid, s2_valid, out_valid, out_ovf, out_data and ovf_count to 0. Release is synchronous to Clk. A reset mid-stream discards in-flight words; nothing is replayed.
- Transfer: a word moves on a handshake when valid && ready at a rising edge. in_data must be held stable while in_valid=1 && in_ready=0.
- Stage 1 (S1):
  - Registers the input.
  - Computes fit = (in_data[IN_W-1:OUT_W-1] all 0s or all 1s).
  - Computes trunc = in_data[OUT_W-1:0].
- Stage 2 (S2): registers the S1 result onto out_data and out_ovf, with out_ovf = !fit.
- Stall logic:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational, no dependency on in_valid).
- Latency and throughput:
  - 2 cycles from input handshake to out_valid, with no backpressure.
  - One word per cycle sustained while out_ready=1.
- Backpressure: with out_ready=0 the pipeline holds at most 2 words, then in_ready=0. out_data and out_ovf are stable while out_valid && !out_ready.
- Empty pipeline: out_valid=0; out_data and out_ovf hold their last values.
- Ordering: strict in-order delivery; no word is dropped or duplicated.
- ovf_count:
  - Increments by 1 on each output handshake where out_ovf=1.
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr=1 forces 0 and has priority over a simultaneous increment; that event is not counted.
- Arithmetic invariant: when out_ovf=0, sign-extending out_data to IN_W equals the original in_data exactly.

Optional Feature:
Macro SIGN_NARROW_SATURATE_EN.
- Defined: on overflow, out_data saturates.
  - Positive inputs (in_data[IN_W-1]=0) give 0x1FFFFFF (max positive).
  - Negative inputs give 0x2000000 (min negative).
- Undefined: on overflow, out_data = in_data[OUT_W-1:0] (wrap).
- out_ovf and ovf_count behave identically in both builds.

Test Plan:
- Reset then single word: in_data=0x00000005, out_ready=1 -> out_valid 2 cycles later; out_data=0x0000005, out_ovf=0, ovf_count=0.
- Negative fit: in_data=0xFFFFFFFB -> out_data=0x3FFFFFB, out_ovf=0; re-extension gives 0xFFFFFFFB.
- Overflow, both builds:
  - in_data=0x02000000 -> out_ovf=1, ovf_count=1; out_data=0x2000000 (wrap) or 0x1FFFFFF (SATURATE_EN).
  - in_data=0xFDFFFFFF -> out_ovf=1; out_data=0x1FFFFFF (wrap) or 0x2000000 (SATURATE_EN).
- Backpressure:
  - Stream 0x1,0x2,0x3,0x4 with out_ready=0 -> in_ready drops after 2 accepted words, out_data held at 0x0000001.
  - Release out_ready -> outputs 0x1..0x4 in order, no gaps once flowing.
- Counter edges:
  - Preload ovf_count near max via repeated overflow words (CNT_W=4 build) -> holds at 15.
  - cnt_clr asserted in the same cycle as an overflow handshake -> ovf_count=0.
- Async reset mid-stream: assert Rst_n=0 with both stages full -> out_valid=0 and in_ready=1 immediately; after release, a fresh word 0x7 emerges 2 cycles after handshake with no stale data.
